// File: rtl/candidate_window_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : face_detect_pkg
// Purpose  : Shared widths, collector state encoding, coordinate-pair type
//            and the absolute-difference helper used by duplicate detection.
// Revision : 1.0 - initial release
// ============================================================================
package face_detect_pkg;

  localparam int DATA_WIDTH_12 = 12;
  localparam int DATA_WIDTH_8  = 8;

  // Frame sequencing states
  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    CLOSE   = 1'b1
  } state_e;

  // One stored candidate position (window top-left, original frame)
  typedef struct packed {
    logic [DATA_WIDTH_12-1:0] x;
    logic [DATA_WIDTH_12-1:0] y;
  } coord_t;

  // Unsigned |a - b| computed one bit wider so nothing wraps
  function automatic logic [DATA_WIDTH_12:0] abs_diff(
    input logic [DATA_WIDTH_12-1:0] a,
    input logic [DATA_WIDTH_12-1:0] b
  );
    logic [DATA_WIDTH_12:0] wa;
    logic [DATA_WIDTH_12:0] wb;
    wa = {1'b0, a};
    wb = {1'b0, b};
    return (wa >= wb) ? (wa - wb) : (wb - wa);
  endfunction

endpackage
`default_nettype wire

// File: rtl/candidate_window_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : candidate_window_collector_if
// Purpose  : Bundles the cascade-result inputs, frame strobes, FIFO read
//            side and statistics outputs of the candidate collector.
// Revision : 1.0 - initial release
// ============================================================================
interface candidate_window_collector_if #(
  parameter int FIFO_ADDR_WIDTH = 4
);
  import face_detect_pkg::*;

  logic                       i_frame_start;
  logic                       i_frame_end;
  logic                       i_inspect_done;
  logic                       i_candidate;
  logic [DATA_WIDTH_12-1:0]   i_window_x;
  logic [DATA_WIDTH_12-1:0]   i_window_y;
  logic                       i_read;
  logic                       o_valid;
  logic [DATA_WIDTH_12-1:0]   o_x;
  logic [DATA_WIDTH_12-1:0]   o_y;
  logic [FIFO_ADDR_WIDTH:0]   o_fill;
  logic [DATA_WIDTH_8-1:0]    o_hit_count;
  logic [DATA_WIDTH_8-1:0]    o_suppressed_count;
  logic                       o_overflow;
  logic                       o_frame_done;

  // Upstream cascade / host side
  modport master (
    output i_frame_start, i_frame_end, i_inspect_done, i_candidate,
           i_window_x, i_window_y, i_read,
    input  o_valid, o_x, o_y, o_fill, o_hit_count, o_suppressed_count,
           o_overflow, o_frame_done
  );

  // Collector side
  modport slave (
    input  i_frame_start, i_frame_end, i_inspect_done, i_candidate,
           i_window_x, i_window_y, i_read,
    output o_valid, o_x, o_y, o_fill, o_hit_count, o_suppressed_count,
           o_overflow, o_frame_done
  );

endinterface
`default_nettype wire

// File: rtl/candidate_window_collector_fifo.sv
`default_nettype none
// ============================================================================
// Module   : candidate_fifo
// Purpose  : First-word-fall-through synchronous FIFO of coordinate pairs.
//            A write while full is only accepted when a pop happens in the
//            same cycle; a pop while empty is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module candidate_fifo
  import face_detect_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_i,
  input  coord_t                wr_data_i,
  input  logic                  rd_i,
  output coord_t                rd_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_WIDTH:0]   fill_o
);

  localparam logic [ADDR_WIDTH:0]   C_DEPTH    = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   C_FILL_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE  = 1;

  coord_t                mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [ADDR_WIDTH:0]   fill_q;
  logic [ADDR_WIDTH:0]   fill_d;
  logic                  w_rd_eff;
  logic                  w_wr_eff;

  assign empty_o   = (fill_q == '0);
  assign full_o    = (fill_q == C_DEPTH);
  assign fill_o    = fill_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so full+read+write keeps the entry
  assign w_rd_eff = rd_i & ~empty_o;
  assign w_wr_eff = wr_i & (~full_o | w_rd_eff);

  // Occupancy next-state
  always_comb begin
    fill_d = fill_q;
    case ({w_wr_eff, w_rd_eff})
      2'b10:   fill_d = fill_q + C_FILL_ONE;
      2'b01:   fill_d = fill_q - C_FILL_ONE;
      default: fill_d = fill_q;
    endcase
  end

  // Pointer and occupancy registers; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (w_wr_eff) wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
      if (w_rd_eff) rd_ptr_q <= rd_ptr_q + C_PTR_ONE;
      fill_q <= fill_d;
    end
  end

  // Storage array, contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_wr_eff) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule
`default_nettype wire

// File: rtl/candidate_window_collector.sv
`default_nettype none
// ============================================================================
// Module   : candidate_window_collector
// Purpose  : Detects cascade inspect-done edges, suppresses hits close to the
//            last stored hit, queues accepted positions in an FWFT FIFO and
//            keeps per-frame hit/suppress/overflow statistics.
// Revision : 1.0 - initial release
// ============================================================================
module candidate_window_collector
  import face_detect_pkg::*;
#(
  parameter int FIFO_DEPTH      = 16,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int SUPPRESS_DIST   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  candidate_window_collector_if.slave   bus
);

  localparam logic [DATA_WIDTH_12:0]  C_DIST        = (DATA_WIDTH_12+1)'(SUPPRESS_DIST);
  localparam bit                      C_SUPPRESS_EN = (SUPPRESS_DIST != 0);
  localparam logic [DATA_WIDTH_8-1:0] C_CNT_ONE     = 1;
  localparam logic [DATA_WIDTH_8-1:0] C_CNT_MAX     = '1;

  // Event detect and stage-1 sample
  logic   inspect_prev_q;
  logic   s1_cand_q;
  coord_t s1_coord_q;
  logic   w_event;

  // Suppression reference and statistics
  coord_t                  last_q,  last_d;
  logic                    ref_q,   ref_d;
  logic [DATA_WIDTH_8-1:0] hit_q,   hit_d;
  logic [DATA_WIDTH_8-1:0] supp_q,  supp_d;
  logic                    ovf_q,   ovf_d;

  // Frame sequencing
  state_e state_q, state_d;
  logic   done_q,  done_d;

  // FIFO hookup
  coord_t                   w_head;
  logic                     w_full;
  logic                     w_empty;
  logic [FIFO_ADDR_WIDTH:0] w_fill;
  logic                     w_dup;
  logic                     w_accept;
  logic                     w_drop;

  assign w_event = bus.i_inspect_done & ~inspect_prev_q;

  // Capture the window result on the inspect-done rising edge
  always_ff @(posedge clk) begin
    if (reset) begin
      inspect_prev_q <= 1'b0;
      s1_cand_q      <= 1'b0;
      s1_coord_q     <= '0;
    end else begin
      inspect_prev_q <= bus.i_inspect_done;
      s1_cand_q      <= w_event & bus.i_candidate;
      s1_coord_q     <= '{x: bus.i_window_x, y: bus.i_window_y};
    end
  end

  assign w_dup = C_SUPPRESS_EN & ref_q
               & (abs_diff(s1_coord_q.x, last_q.x) <= C_DIST)
               & (abs_diff(s1_coord_q.y, last_q.y) <= C_DIST);

  assign w_accept = s1_cand_q & ~w_dup;
  // Full implies non-empty, so any read in this cycle makes room
  assign w_drop   = w_accept & w_full & ~bus.i_read;

  // Reference/statistics next-state; a frame start overrides stage-1 updates
  always_comb begin
    last_d = last_q;
    ref_d  = ref_q;
    hit_d  = hit_q;
    supp_d = supp_q;
    ovf_d  = ovf_q;
    if (w_accept) begin
      last_d = s1_coord_q;
      ref_d  = 1'b1;
      if (hit_q != C_CNT_MAX) hit_d = hit_q + C_CNT_ONE;
    end
    if (s1_cand_q && w_dup && (supp_q != C_CNT_MAX)) supp_d = supp_q + C_CNT_ONE;
    if (w_drop) ovf_d = 1'b1;
    if (bus.i_frame_start) begin
      ref_d  = 1'b0;
      hit_d  = '0;
      supp_d = '0;
      ovf_d  = 1'b0;
    end
  end

  // Reference/statistics registers
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= '0;
      ref_q  <= 1'b0;
      hit_q  <= '0;
      supp_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      last_q <= last_d;
      ref_q  <= ref_d;
      hit_q  <= hit_d;
      supp_q <= supp_d;
      ovf_q  <= ovf_d;
    end
  end

  // Frame FSM next-state: CLOSE holds one cycle to let stage 1 drain
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      COLLECT: if (bus.i_frame_end) state_d = CLOSE;
      CLOSE: begin
        state_d = COLLECT;
        done_d  = 1'b1;
      end
      default: state_d = COLLECT;
    endcase
  end

  // Frame FSM state and registered done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= COLLECT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  candidate_fifo #(
    .DEPTH      (FIFO_DEPTH),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_i      (w_accept),
    .wr_data_i (s1_coord_q),
    .rd_i      (bus.i_read),
    .rd_data_o (w_head),
    .full_o    (w_full),
    .empty_o   (w_empty),
    .fill_o    (w_fill)
  );

  // Head is forced to zero while empty so outputs are clean out of reset
  assign bus.o_valid            = ~w_empty;
  assign bus.o_x                = w_empty ? '0 : w_head.x;
  assign bus.o_y                = w_empty ? '0 : w_head.y;
  assign bus.o_fill             = w_fill;
  assign bus.o_hit_count        = hit_q;
  assign bus.o_suppressed_count = supp_q;
  assign bus.o_overflow         = ovf_q;
  assign bus.o_frame_done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_candidate_window_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_candidate_window_collector
// Purpose  : Self-checking bench for the candidate window collector. A small
//            reference model predicts FIFO contents and frame statistics.
// Revision : 1.0 - initial release
// ============================================================================
module tb_candidate_window_collector;
  import face_detect_pkg::*;

  localparam int DIST  = 2;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  candidate_window_collector_if #(.FIFO_ADDR_WIDTH(4)) bus ();

  candidate_window_collector #(
    .FIFO_DEPTH      (DEPTH),
    .FIFO_ADDR_WIDTH (4),
    .SUPPRESS_DIST   (DIST)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  coord_t exp_q [$];
  bit     m_ref;
  int     m_lx, m_ly, m_hits, m_supp;
  bit     m_ovf;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_clear_frame();
    m_hits = 0; m_supp = 0; m_ovf = 0; m_ref = 0;
  endtask

  // One inspect-done event; rd means a pop lands in the same edge as the write
  task automatic model_event(input int x, input int y, input bit cand, input bit rd);
    int  dx, dy;
    bit  dup;
    coord_t c;
    if (rd && exp_q.size() > 0) void'(exp_q.pop_front());
    if (!cand) return;
    dx  = (x > m_lx) ? x - m_lx : m_lx - x;
    dy  = (y > m_ly) ? y - m_ly : m_ly - y;
    dup = m_ref && (DIST != 0) && (dx <= DIST) && (dy <= DIST);
    if (dup) begin
      if (m_supp < 255) m_supp++;
    end else begin
      if (m_hits < 255) m_hits++;
      m_lx = x; m_ly = y; m_ref = 1;
      c.x = 12'(x); c.y = 12'(y);
      if (exp_q.size() < DEPTH) exp_q.push_back(c);
      else m_ovf = 1;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_fill"},  bus.o_fill, exp_q.size());
    check({tag, "_valid"}, bus.o_valid, (exp_q.size() > 0) ? 1 : 0);
    check({tag, "_hits"},  bus.o_hit_count, m_hits);
    check({tag, "_supp"},  bus.o_suppressed_count, m_supp);
    check({tag, "_ovf"},   bus.o_overflow, m_ovf);
  endtask

  // Edge in cycle N; optional read / frame start in the stage-1 cycle N+1
  task automatic send(input int x, input int y, input bit cand, input bit rd, input bit fs);
    @(posedge clk); #1;
    bus.i_inspect_done = 1'b1;
    bus.i_candidate    = cand;
    bus.i_window_x     = 12'(x);
    bus.i_window_y     = 12'(y);
    @(posedge clk); #1;
    bus.i_inspect_done = 1'b0;
    bus.i_candidate    = 1'b0;
    bus.i_read         = rd;
    bus.i_frame_start  = fs;
    if (rd && exp_q.size() > 0) begin
      check("rw_head_x", bus.o_x, exp_q[0].x);
      check("rw_head_y", bus.o_y, exp_q[0].y);
    end
    @(posedge clk); #1;
    bus.i_read        = 1'b0;
    bus.i_frame_start = 1'b0;
    model_event(x, y, cand, rd);
    if (fs) model_clear_frame();
  endtask

  task automatic pop_check(input string tag);
    coord_t e;
    e = exp_q.pop_front();
    check({tag, "_valid"}, bus.o_valid, 1);
    check({tag, "_x"}, bus.o_x, e.x);
    check({tag, "_y"}, bus.o_y, e.y);
    bus.i_read = 1'b1;
    @(posedge clk); #1;
    bus.i_read = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) pop_check(tag);
    check({tag, "_empty"}, bus.o_valid, 0);
  endtask

  task automatic pulse_fs();
    @(posedge clk); #1; bus.i_frame_start = 1'b1;
    @(posedge clk); #1; bus.i_frame_start = 1'b0;
    model_clear_frame();
  endtask

  initial begin
    reset = 1'b1;
    bus.i_frame_start = 0; bus.i_frame_end = 0; bus.i_inspect_done = 0;
    bus.i_candidate = 0; bus.i_window_x = '0; bus.i_window_y = '0; bus.i_read = 0;
    m_lx = 0; m_ly = 0;
    model_clear_frame();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_state("reset");
    check("reset_x", bus.o_x, 0);
    check("reset_done", bus.o_frame_done, 0);

    // Single hit with latency check
    @(posedge clk); #1;
    bus.i_inspect_done = 1; bus.i_candidate = 1; bus.i_window_x = 12'd40; bus.i_window_y = 12'd25;
    @(posedge clk); #1;
    bus.i_inspect_done = 0; bus.i_candidate = 0;
    check("lat_n1_valid", bus.o_valid, 0);
    @(posedge clk); #1;
    model_event(40, 25, 1, 0);
    check("lat_n2_valid", bus.o_valid, 1);
    check("single_x", bus.o_x, 40);
    check("single_y", bus.o_y, 25);
    check_state("single");

    // Duplicate suppression, then just beyond the radius
    send(41, 27, 1, 0, 0);
    check_state("dup");
    send(43, 25, 1, 0, 0);
    check_state("dx3");

    // Level held high gives one event
    @(posedge clk); #1;
    bus.i_inspect_done = 1; bus.i_candidate = 1; bus.i_window_x = 12'd10; bus.i_window_y = 12'd10;
    repeat (5) @(posedge clk);
    #1 bus.i_inspect_done = 0; bus.i_candidate = 0;
    @(posedge clk); #1;
    model_event(10, 10, 1, 0);
    check_state("level");
    send(100, 100, 0, 0, 0);
    check_state("noncand");
    drain("drain1");

    // Read while empty is ignored
    bus.i_read = 1; @(posedge clk); #1; bus.i_read = 0;
    check_state("rd_empty");

    // Frame end -> done two cycles later
    bus.i_frame_end = 1;
    @(posedge clk); #1; bus.i_frame_end = 0;
    check("done_e1", bus.o_frame_done, 0);
    @(posedge clk); #1;
    check("done_e2", bus.o_frame_done, 1);
    @(posedge clk); #1;
    check("done_e3", bus.o_frame_done, 0);
    check_state("counts_kept");
    pulse_fs();
    check_state("fs_clear");
    send(m_lx, m_ly, 1, 0, 0);
    check_state("after_fs_hit");

    // Frame start coinciding with a stage-1 write
    send(600, 600, 1, 0, 1);
    check_state("fs_coincide");
    send(600, 600, 1, 0, 0);
    check_state("fs_ref_invalid");
    drain("drain2");

    // Overflow: 17 hits, no reads
    pulse_fs();
    for (int i = 0; i < 17; i++) send(100 + 10*i, 300, 1, 0, 0);
    check_state("overflow");
    drain("ovf_drain");

    // Full with simultaneous read and write
    pulse_fs();
    for (int i = 0; i < 16; i++) send(100 + 10*i, 500, 1, 0, 0);
    send(900, 500, 1, 1, 0);
    check_state("full_rw");
    drain("rw_drain");

    // Mid-frame reset discards everything
    send(7, 7, 1, 0, 0);
    reset = 1; @(posedge clk); @(posedge clk); #1 reset = 0;
    exp_q.delete(); model_clear_frame(); m_lx = 0; m_ly = 0;
    check_state("mid_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/candidate_window_collector.md
Name: candidate_window_collector

Overview:
- Sits directly downstream of the integral-image/cascade stage and consumes its per-window result (inspect-done plus candidate flag) together with the window's original-frame coordinates.
- Keeps accepted face-candidate window positions in a first-word-fall-through FIFO for the host/display logic to read.
- Suppresses near-duplicate hits that fall inside a window of the last stored hit.
- Keeps per-frame statistics and raises a frame-done pulse.

Parameters:
- DATA_WIDTH_12, 12, coordinate width.
- DATA_WIDTH_8, 8, width of the per-frame counters.
- FIFO_DEPTH, 16, number of stored candidates (power of two).
- FIFO_ADDR_WIDTH, 4, log2(FIFO_DEPTH).
- SUPPRESS_DIST, 2, duplicate radius in pixels; 0 disables suppression.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- i_frame_start, input, 1, one-cycle pulse at the start of a new frame.
- i_frame_end, input, 1, one-cycle pulse after the last window of the frame.
- i_inspect_done, input, 1, cascade finished the current window (level; an event is its rising edge).
- i_candidate, input, 1, window passed all stages; valid on the inspect-done rising-edge cycle.
- i_window_x, input, DATA_WIDTH_12, original-frame x of the window top-left.
- i_window_y, input, DATA_WIDTH_12, original-frame y of the window top-left.
- i_read, input, 1, pop the FIFO head.
- o_valid, output, 1, FIFO not empty.
- o_x, output, DATA_WIDTH_12, head entry x.
- o_y, output, DATA_WIDTH_12, head entry y.
- o_fill, output, FIFO_ADDR_WIDTH+1, current FIFO occupancy.
- o_hit_count, output, DATA_WIDTH_8, candidates accepted this frame (saturating).
- o_suppressed_count, output, DATA_WIDTH_8, candidates suppressed this frame (saturating).
- o_overflow, output, 1, sticky: an accepted candidate was dropped because the FIFO was full.
- o_frame_done, output, 1, one-cycle pulse.

Behaviour:
- Reset: all outputs 0; FIFO empty; "last stored" reference invalid; state COLLECT.
- Event detect:
  - A register holds the previous i_inspect_done.
  - An event is i_inspect_done=1 with previous=0 (cycle N).
  - The x, y and candidate inputs are sampled in cycle N.
  - A level held high across cycles produces exactly one event.
- Stage 1 (cycle N+1), registered sample:
  - Compute |x - last_x| <= SUPPRESS_DIST and |y - last_y| <= SUPPRESS_DIST using unsigned absolute difference on DATA_WIDTH_12+1 bits; no wrap.
  - The sample is a duplicate only if the reference is valid and both tests hold.
- Stage 1 end-of-cycle outcomes:
  - Candidate and not duplicate: write to the FIFO, update last_x/last_y, set reference valid, hit_count+1.
  - Candidate and duplicate: no write; suppressed_count+1.
  - Non-candidate: no action.
- Latency: o_valid rises at N+2 for a write into an empty FIFO.
- FIFO (first-word fall-through):
  - o_x and o_y show the head whenever o_valid=1.
  - i_read while o_valid=1 pops at the clock edge; i_read while empty is ignored.
  - Simultaneous write and read when full: both happen; occupancy is unchanged and nothing is dropped.
  - Simultaneous write and read when empty: the write happens and the read is ignored.
  - Write when full without a read: the entry is dropped, o_overflow is set, hit_count still increments, and last_x/last_y still update.
  - Pointers wrap modulo FIFO_DEPTH.
- Counters saturate at 255.
- State machine, COLLECT to CLOSE:
  - COLLECT goes to CLOSE on i_frame_end.
  - CLOSE waits one cycle so an in-flight stage-1 sample completes.
  - CLOSE then pulses o_frame_done for one cycle and returns to COLLECT.
  - Counts stay readable until the next i_frame_start.
- i_frame_start:
  - Clears hit_count, suppressed_count, o_overflow and the reference valid bit, next cycle.
  - Does not flush the FIFO.
  - If it coincides with a stage-1 write, the write proceeds, the counters end at 0 (clear wins), and the reference stays invalid.
- Events arriving in CLOSE are processed normally and counted in the current frame.
- A reset mid-frame discards all state, including FIFO contents.

Decomposition:
- Shared package (face_detect_pkg):
  - DATA_WIDTH_12 and DATA_WIDTH_8.
  - State encoding constants COLLECT=0 and CLOSE=1.
  - A coordinate-pair struct typedef {x, y}.
- One natural sub-module: candidate_fifo, a parameterised FWFT synchronous FIFO with write, read, full, empty and fill.
- The event detect, suppression logic and counters stay in the top module.

Test Plan:
- Single hit: reset; i_inspect_done rises with candidate=1, x=40, y=25 at cycle 10 -> o_valid=1 at cycle 12, o_x=40, o_y=25, o_hit_count=1, o_fill=1.
- Duplicate suppression: hits at (40,25) then (41,27) -> one FIFO entry, hit_count=1, suppressed_count=1; a third hit at (43,25) is stored (dx=3 exceeds 2).
- Level hold and non-candidate: i_inspect_done held high for 5 cycles with candidate=1 at (10,10) -> exactly one entry; an edge with candidate=0 -> no entry, counts unchanged.
- Overflow: 17 distinct hits 10 px apart with no reads -> o_fill=16, o_overflow=1, hit_count=17; 16 reads return the first 16 coordinates in order, then o_valid=0.
- Full plus simultaneous read/write: FIFO full, i_read asserted in the write cycle -> o_fill stays 16 and o_overflow stays 0.
- Frame sequencing: i_frame_end -> o_frame_done pulses exactly 2 cycles later; i_frame_start then clears the counts and overflow; a hit at the last stored coordinate after i_frame_start is stored, not suppressed.
